// File: rtl/mult8_err_monitor.sv
// Streaming error-statistics monitor for an approximate WIDTHxWIDTH multiplier.
// Optional feature macro SIGNED_BIAS_EN adds the signed error-bias accumulator output err_bias.
module mult8_err_monitor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 17,
    parameter int unsigned SUM_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2*WIDTH-1:0] in_p,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   err_count,
    output logic [SUM_W-1:0]   sum_abs_err,
    output logic [2*WIDTH-1:0] max_abs_err,
    output logic [WIDTH-1:0]   worst_a,
    output logic [WIDTH-1:0]   worst_b
`ifdef SIGNED_BIAS_EN
    ,
    output logic signed [SUM_W-1:0] err_bias
`endif
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned ACC_W = ((SUM_W > PW) ? SUM_W : PW) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] acc_cnt;
    logic             accept;
    logic             last_accept;
    logic             start_ok;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [PW-1:0]    s1_p;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_a, s2_b;
    logic [PW-1:0]    s2_abs;
    logic             s2_mis;

    logic [PW-1:0]    exact_c;
    logic [PW-1:0]    abs_c;
    logic [ACC_W-1:0] sum_ext_c;
    logic [SUM_W-1:0] sum_nxt_c;

    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (acc_cnt == (n_q - CNT_W'(1)));
    assign start_ok    = start && ((state_q == IDLE) || (state_q == DONE));

    // Next-state logic; start only takes effect from IDLE or DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = (num_samples == '0) ? DONE : RUN;
            end
            RUN:     if (last_accept) state_d = DRAIN;
            DRAIN:   if (!s1_valid && !s2_valid) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Status outputs registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_ready <= (state_d == RUN);
            busy     <= (state_d == RUN) || (state_d == DRAIN);
            done     <= (state_d == DONE);
        end
    end

    // Window length and accepted-sample counter; the counter stops at N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q     <= '0;
            acc_cnt <= '0;
        end else if (start_ok) begin
            n_q     <= num_samples;
            acc_cnt <= '0;
        end else if (accept && (acc_cnt != n_q)) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        exact_c = PW'(s1_a) * PW'(s1_b);
        abs_c   = (s1_p >= exact_c) ? (s1_p - exact_c) : (exact_c - s1_p);
    end

    always_comb begin
        sum_ext_c = ACC_W'(sum_abs_err) + ACC_W'(s2_abs);
        sum_nxt_c = (sum_ext_c > ACC_W'(SUM_MAX)) ? SUM_MAX : SUM_W'(sum_ext_c);
    end

`ifdef SIGNED_BIAS_EN
    localparam int unsigned DW = PW + 1;
    localparam int unsigned BW = ((SUM_W > DW) ? SUM_W : DW) + 1;
    localparam logic signed [SUM_W-1:0] BIAS_MAX = {1'b0, {(SUM_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] BIAS_MIN = {1'b1, {(SUM_W-1){1'b0}}};

    logic signed [DW-1:0]    diff_c;
    logic signed [DW-1:0]    s2_diff;
    logic signed [BW-1:0]    bias_ext_c;
    logic signed [SUM_W-1:0] bias_nxt_c;

    // Signed P - exact, then a saturating signed accumulate.
    always_comb begin
        diff_c     = $signed({1'b0, s1_p}) - $signed({1'b0, exact_c});
        bias_ext_c = BW'(err_bias) + BW'(s2_diff);
        if (bias_ext_c > BW'(BIAS_MAX))      bias_nxt_c = BIAS_MAX;
        else if (bias_ext_c < BW'(BIAS_MIN)) bias_nxt_c = BIAS_MIN;
        else                                 bias_nxt_c = SUM_W'(bias_ext_c);
    end
`endif

    // S1 captures the accepted triple; S2 holds the error terms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_p     <= '0;
            s2_valid <= 1'b0;
            s2_a     <= '0;
            s2_b     <= '0;
            s2_abs   <= '0;
            s2_mis   <= 1'b0;
`ifdef SIGNED_BIAS_EN
            s2_diff  <= '0;
`endif
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a <= in_a;
                s1_b <= in_b;
                s1_p <= in_p;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_a    <= s1_a;
                s2_b    <= s1_b;
                s2_abs  <= abs_c;
                s2_mis  <= (abs_c != '0);
`ifdef SIGNED_BIAS_EN
                s2_diff <= diff_c;
`endif
            end
        end
    end

    // S3: statistics; strict greater-than keeps the first worst sample on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            worst_a     <= '0;
            worst_b     <= '0;
`ifdef SIGNED_BIAS_EN
            err_bias    <= '0;
`endif
        end else if (start_ok) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            worst_a     <= '0;
            worst_b     <= '0;
`ifdef SIGNED_BIAS_EN
            err_bias    <= '0;
`endif
        end else if (s2_valid) begin
            if (s2_mis) err_count <= err_count + CNT_W'(1);
            sum_abs_err <= sum_nxt_c;
            if (s2_abs > max_abs_err) begin
                max_abs_err <= s2_abs;
                worst_a     <= s2_a;
                worst_b     <= s2_b;
            end
`ifdef SIGNED_BIAS_EN
            err_bias <= bias_nxt_c;
`endif
        end
    end
endmodule

// File: tb/tb_mult8_err_monitor.sv
// Self-checking bench for mult8_err_monitor: a behavioural model pushes expected window
// statistics to a scoreboard queue, popped and compared when done rises.
`timescale 1ns/1ps
module tb_mult8_err_monitor;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 17;
    localparam int unsigned SUM_W = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   num_samples = '0;
    logic               in_valid = 1'b0;
    logic [WIDTH-1:0]   in_a = '0;
    logic [WIDTH-1:0]   in_b = '0;
    logic [2*WIDTH-1:0] in_p = '0;

    logic               in_ready, busy, done;
    logic [CNT_W-1:0]   err_count;
    logic [SUM_W-1:0]   sum_abs_err;
    logic [2*WIDTH-1:0] max_abs_err;
    logic [WIDTH-1:0]   worst_a, worst_b;

    logic               in_ready8, busy8, done8;
    logic [CNT_W-1:0]   err_count8;
    logic [7:0]         sum8;
    logic [2*WIDTH-1:0] max8;
    logic [WIDTH-1:0]   wa8, wb8;
`ifdef SIGNED_BIAS_EN
    logic signed [SUM_W-1:0] err_bias;
    logic signed [7:0]       bias8;
`endif

    mult8_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_p(in_p),
        .busy(busy), .done(done), .err_count(err_count), .sum_abs_err(sum_abs_err),
        .max_abs_err(max_abs_err), .worst_a(worst_a), .worst_b(worst_b)
`ifdef SIGNED_BIAS_EN
        , .err_bias(err_bias)
`endif
    );

    // Narrow-accumulator instance sharing the same stimulus, for saturation checks.
    mult8_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SUM_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b), .in_p(in_p),
        .busy(busy8), .done(done8), .err_count(err_count8), .sum_abs_err(sum8),
        .max_abs_err(max8), .worst_a(wa8), .worst_b(wb8)
`ifdef SIGNED_BIAS_EN
        , .err_bias(bias8)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint err;
        longint sum;
        longint sum8;
        longint maxe;
        longint bias;
        int     wa;
        int     wb;
        int     lat;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     failures = 0;
    bit     m_active = 1'b0;
    int     m_n = 0;
    int     m_cnt = 0;
    longint m_err, m_sum, m_sum8, m_max, m_bias;
    int     m_wa, m_wb;
    int     last_acc_cyc = 0;

    function automatic void model_clear();
        m_err = 0; m_sum = 0; m_sum8 = 0; m_max = 0; m_bias = 0;
        m_wa = 0; m_wb = 0;
    endfunction

    function automatic void push_exp(input int lat);
        exp_t e;
        e.err = m_err; e.sum = m_sum; e.sum8 = m_sum8; e.maxe = m_max; e.bias = m_bias;
        e.wa = m_wa; e.wb = m_wb; e.lat = lat;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window(input int n);
        start = 1'b1;
        num_samples = CNT_W'(n);
        tick();
        start = 1'b0;
        model_clear();
        m_n = n;
        m_cnt = 0;
        m_active = (n != 0);
        if (n == 0) begin
            last_acc_cyc = cyc;
            push_exp(0);
        end
        checks++;
        if (done !== (n == 0) || err_count !== '0 || sum_abs_err !== '0 || max_abs_err !== '0) begin
            failures++;
            $display("FAIL start_clear n=%0d: done=%b err=%0d sum=%0d max=%0d, want done=%b stats 0",
                     n, done, err_count, sum_abs_err, max_abs_err, (n == 0));
        end
    endtask

    task automatic send(input int a, input int b, input int p, input bit v);
        bit acc;
        int e, ae;
        in_a = WIDTH'(a);
        in_b = WIDTH'(b);
        in_p = (2*WIDTH)'(p);
        in_valid = v;
        checks++;
        if (in_ready !== m_active) begin
            failures++;
            $display("FAIL in_ready: got %b want %b (a=%0d b=%0d)", in_ready, m_active, a, b);
        end
        acc = v && m_active;
        tick();
        in_valid = 1'b0;
        if (acc) begin
            e  = p - a * b;
            ae = (e < 0) ? -e : e;
            if (ae != 0) m_err++;
            m_sum  = (m_sum + ae > 64'd4294967295) ? 64'd4294967295 : m_sum + ae;
            m_sum8 = (m_sum8 + ae > 255) ? 255 : m_sum8 + ae;
            if (ae > m_max) begin
                m_max = ae; m_wa = a; m_wb = b;
            end
            m_bias = m_bias + e;
            if (m_bias > 64'sd2147483647) m_bias = 64'sd2147483647;
            if (m_bias < -64'sd2147483648) m_bias = -64'sd2147483648;
            m_cnt++;
            if (m_cnt == m_n) begin
                m_active = 1'b0;
                last_acc_cyc = cyc;
                push_exp(3);
            end
        end
    endtask

    task automatic wait_done(input string name);
        exp_t e;
        int   n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, want 1", name, done, n);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard: done=1 but no expected window queued", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (cyc - last_acc_cyc !== e.lat) begin
            failures++;
            $display("FAIL %s_latency: got %0d want %0d", name, cyc - last_acc_cyc, e.lat);
        end
        checks++;
        if (err_count !== CNT_W'(e.err)) begin
            failures++;
            $display("FAIL %s_err_count: got %0d want %0d", name, err_count, e.err);
        end
        checks++;
        if (sum_abs_err !== SUM_W'(e.sum)) begin
            failures++;
            $display("FAIL %s_sum_abs_err: got %0d want %0d", name, sum_abs_err, e.sum);
        end
        checks++;
        if (max_abs_err !== (2*WIDTH)'(e.maxe)) begin
            failures++;
            $display("FAIL %s_max_abs_err: got %0d want %0d", name, max_abs_err, e.maxe);
        end
        checks++;
        if (worst_a !== WIDTH'(e.wa) || worst_b !== WIDTH'(e.wb)) begin
            failures++;
            $display("FAIL %s_worst: got (%0d,%0d) want (%0d,%0d)", name, worst_a, worst_b, e.wa, e.wb);
        end
        checks++;
        if (sum8 !== 8'(e.sum8)) begin
            failures++;
            $display("FAIL %s_sum_sat8: got %0d want %0d", name, sum8, e.sum8);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_flags: busy=%b in_ready=%b want 0 0", name, busy, in_ready);
        end
`ifdef SIGNED_BIAS_EN
        checks++;
        if (err_bias !== SUM_W'(e.bias)) begin
            failures++;
            $display("FAIL %s_err_bias: got %0d want %0d", name, err_bias, e.bias);
        end
`endif
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s_flags: in_ready=%b busy=%b done=%b want 0 0 0", name, in_ready, busy, done);
        end
        checks++;
        if (err_count !== '0 || sum_abs_err !== '0 || max_abs_err !== '0 ||
            worst_a !== '0 || worst_b !== '0) begin
            failures++;
            $display("FAIL %s_stats: err=%0d sum=%0d max=%0d worst=(%0d,%0d) want all 0",
                     name, err_count, sum_abs_err, max_abs_err, worst_a, worst_b);
        end
`ifdef SIGNED_BIAS_EN
        checks++;
        if (err_bias !== '0) begin
            failures++;
            $display("FAIL %s_bias: got %0d want 0", name, err_bias);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        in_valid = 1'b1;
        num_samples = CNT_W'(7);
        in_a = 8'd33; in_b = 8'd44; in_p = 16'd999;
        repeat (3) tick();
        check_zero_outputs("reset_held");
        start = 1'b0;
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
        check_zero_outputs("reset_release");
        model_clear();
    endtask

    task automatic test_exact_stream();
        start_window(4);
        send(3, 5, 15, 1'b1);
        send(0, 200, 0, 1'b1);
        send(255, 255, 65025, 1'b1);
        send(16, 16, 256, 1'b1);
        wait_done("exact");
    endtask

    task automatic test_errors();
        start_window(3);
        send(10, 10, 96, 1'b1);
        send(255, 255, 65025, 1'b1);
        send(7, 9, 70, 1'b1);
        wait_done("errors");
    endtask

    task automatic test_handshake_gaps();
        start_window(2);
        send(12, 12, 150, 1'b1);
        send(99, 99, 0, 1'b0);
        send(99, 99, 0, 1'b0);
        send(20, 3, 58, 1'b1);
        send(1, 1, 1000, 1'b1);
        wait_done("gaps");
    endtask

    task automatic test_tie_saturation();
        start_window(300);
        send(1, 1, 6, 1'b1);
        send(2, 2, 9, 1'b1);
        for (int i = 0; i < 298; i++) send(3, 3, 10, 1'b1);
        wait_done("tie_sat");
    endtask

    task automatic test_control_corners();
        start_window(2);
        send(4, 4, 16, 1'b1);
        start = 1'b1;
        num_samples = CNT_W'(5);
        send(0, 0, 0, 1'b0);
        start = 1'b0;
        send(6, 7, 43, 1'b1);
        wait_done("start_in_run");

        start_window(4);
        send(9, 9, 70, 1'b1);
        send(8, 8, 60, 1'b1);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        tick();
        rst_n = 1'b1;
        m_active = 1'b0;
        model_clear();
        tick();
        check_zero_outputs("after_mid_reset");

        start_window(0);
        wait_done("n_zero");
        start_window(1);
        send(2, 3, 7, 1'b1);
        wait_done("restart_from_done");
        start_window(0);
        wait_done("n_zero_from_done");
    endtask

    initial begin
        test_reset();
        test_exact_stream();
        test_errors();
        test_handshake_gaps();
        test_tie_saturation();
        test_control_corners();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: %0d windows never completed", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
